// File: rtl/spi_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_pkg
//  Description : Shared constants and types for the SPI register link.
//                Frame layout (MSB first): R/W bit, ADDR_W address bits,
//                DATA_W data bits. Also used by spi_master.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_reg_pkg;

    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 16;
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;

    // Bit counter width; must hold the value FRAME_W.
    localparam int CNT_W   = 6;

    // Value of the frame's leading R/W bit.
    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : SYNC_STAGES-deep synchronizer for an asynchronous pin with
//                registered single-cycle rise/fall pulses. A pin edge shows
//                up as a pulse SYNC_STAGES+1 clk later.
//  Ports       : clk, rst       - system clock, synchronous active-high reset
//                din            - asynchronous input pin
//                rise, fall     - one-clk edge pulses (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    // Stages [SYNC_STAGES-1:0] are the synchronizer; the extra top stage is
    // the previous synchronized value used for edge detection.
    logic [SYNC_STAGES:0] r_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset to the pin's idle level so no edge is seen at reset exit
            // while the pin sits idle.
            r_sh <= {(SYNC_STAGES + 1){RESET_VAL}};
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            r_sh <= {r_sh[SYNC_STAGES-1:0], din};
            rise <=  r_sh[SYNC_STAGES-1] & ~r_sh[SYNC_STAGES];
            fall <= ~r_sh[SYNC_STAGES-1] &  r_sh[SYNC_STAGES];
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave
//  Description : Mode-0 SPI slave terminating the register link. SCLK, MOSI
//                and SS are oversampled by clk. 32-bit frames are decoded
//                into one-clk register write/read strobes; read data is
//                returned on MISO during the second half of the same frame.
//  Ports       : clk, rst            - system clock, sync active-high reset
//                SCLK, MOSI, SS      - SPI pins from the master (SS active low)
//                MISO                - read data out, 0 when not driving
//                wr_en/wr_addr/wr_data - write strobe and payload
//                rd_en/rd_addr       - read strobe and address
//                rd_data             - register data, valid 1 clk after rd_en
//                frame_err           - pulse on a truncated frame
//                busy                - frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W      = spi_reg_pkg::ADDR_W,
    parameter int DATA_W      = spi_reg_pkg::DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic              SS,
    output logic              MISO,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              frame_err,
    output logic              busy
);

    localparam int               c_frame_w   = 1 + ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] c_cmd_bits  = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] c_frame_cnt = CNT_W'(c_frame_w);

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic w_sclk_rise, w_sclk_fall;
    logic w_ss_rise,   w_ss_fall;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SCLK),
        .rise (w_sclk_rise),
        .fall (w_sclk_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SS),
        .rise (w_ss_rise),
        .fall (w_ss_fall)
    );

    // MOSI needs no edge detect. Its synchronized value lags the pin by
    // SYNC_STAGES clk, one less than the SCLK edge pulse, and the master
    // holds it stable across the whole SCLK high phase.
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   w_mosi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= SYNC_STAGES'({r_mosi_sync, MOSI});
        end
    end

    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    spi_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [c_frame_w-2:0]   r_shift;     // bits received so far (oldest bit dropped)
    logic [DATA_W-1:0]      r_miso_sr;
    logic                   r_is_read;
    logic                   r_rd_cap;    // rd_data is valid this cycle

    logic [c_frame_w-1:0]   w_shift_next;
    logic [CNT_W-1:0]       w_cnt_next;

    // Frame as it stands after accepting the current MOSI bit.
    assign w_shift_next = {r_shift, w_mosi};
    assign w_cnt_next   = (r_cnt == c_frame_cnt) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_miso_sr <= '0;
            r_is_read <= 1'b0;
            r_rd_cap  <= 1'b0;
            MISO      <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            frame_err <= 1'b0;
            r_rd_cap  <= rd_en;

            // SS edges take priority over any SCLK edge in the same cycle.
            if (w_ss_fall) begin
                r_state   <= ST_CMD;
                r_cnt     <= '0;
                r_shift   <= '0;
                r_is_read <= 1'b0;
                MISO      <= 1'b0;
                busy      <= 1'b1;
            end else if (w_ss_rise) begin
                // Truncated frame: some bits seen but fewer than a full frame.
                if (r_state == ST_DATA || (r_state == ST_CMD && r_cnt != '0)) begin
                    frame_err <= 1'b1;
                end
                r_state <= ST_IDLE;
                MISO    <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        MISO <= 1'b0;
                    end

                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_shift <= w_shift_next[c_frame_w-2:0];
                            r_cnt   <= w_cnt_next;
                            if (w_cnt_next == c_cmd_bits) begin
                                // R/W bit and address are complete.
                                r_state   <= ST_DATA;
                                r_is_read <= (w_shift_next[ADDR_W] == CMD_READ);
                                if (w_shift_next[ADDR_W] == CMD_READ) begin
                                    rd_en   <= 1'b1;
                                    rd_addr <= w_shift_next[ADDR_W-1:0];
                                end
                            end
                        end
                    end

                    ST_DATA: begin
                        if (w_sclk_rise) begin
                            r_shift <= w_shift_next[c_frame_w-2:0];
                            r_cnt   <= w_cnt_next;
                            if (w_cnt_next == c_frame_cnt) begin
                                r_state <= ST_DONE;
                                MISO    <= 1'b0;
                                if (w_shift_next[c_frame_w-1] == CMD_WRITE) begin
                                    wr_en   <= 1'b1;
                                    wr_addr <= w_shift_next[c_frame_w-2 -: ADDR_W];
                                    wr_data <= w_shift_next[DATA_W-1:0];
                                end
                            end
                        end else if (w_sclk_fall && r_is_read) begin
                            MISO      <= r_miso_sr[DATA_W-1];
                            r_miso_sr <= {r_miso_sr[DATA_W-2:0], 1'b0};
                        end
                    end

                    ST_DONE: begin
                        // Extra clocks of an over-length frame are counted
                        // (saturating) but otherwise ignored.
                        MISO <= 1'b0;
                        if (w_sclk_rise) begin
                            r_cnt <= w_cnt_next;
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                        MISO    <= 1'b0;
                    end
                endcase
            end

            // Load read data; the SCLK timing guarantees this lands before
            // the first falling edge that shifts it out.
            if (r_rd_cap) begin
                r_miso_sr <= rd_data;
            end
        end
    end

endmodule
`default_nettype wire
